// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// default parameter values.
package mem_arb_pkg;

  localparam int DEF_ADDRESSIZE    = 32;
  localparam int DEF_DATASIZE      = 64;
  localparam int DEF_MAX_RD_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10
  } state_e;

  function automatic logic is_active(input state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant decision between the write-buffer head and a cache
// line-fill request; returns the state to enter from IDLE.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic   wb_valid,
  input  logic   wb_full,
  input  logic   rd_req,
  input  logic   rd_hazard,
  input  logic   rd_block,
  input  logic   streak_sat,
  output state_e grant
);

  logic write_due;
  logic read_due;

  // Reads win unless the buffer is full, the read would bypass a buffered
  // write to the same line, there is no read, or reads have hogged the port.
  assign write_due = wb_valid & (wb_full | (rd_req & rd_hazard) | ~rd_req | streak_sat);

  // A request still held in its rd_ready cycle has already been served.
  assign read_due  = rd_req & ~rd_block;

  // NOTE: assign a default first in every always_comb so no path leaves the
  // output unassigned; an unassigned path infers a latch.
  always_comb begin
    grant = IDLE;
    if (write_due) begin
      grant = WRITE;
    end else if (read_due) begin
      grant = READ;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared between a write buffer and cache line fills.
// Reads have priority, bounded by a streak counter so writes cannot starve.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESSIZE    = DEF_ADDRESSIZE,
  parameter int DATASIZE      = DEF_DATASIZE,
  parameter int MAX_RD_STREAK = DEF_MAX_RD_STREAK
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_valid,
  input  logic                    wb_full,
  input  logic [ADDRESSIZE-1:0]   wb_address,
  input  logic [8*DATASIZE-1:0]   wb_data,
  input  logic [8*DATASIZE-1:0]   wb_mask,
  output logic                    wb_done,
  input  logic                    rd_req,
  input  logic [ADDRESSIZE-1:0]   rd_address,
  input  logic                    rd_hazard,
  output logic                    rd_ready,
  output logic [8*DATASIZE-1:0]   rd_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESSIZE-1:0]   mem_address,
  output logic [8*DATASIZE-1:0]   mem_wdata,
  output logic [8*DATASIZE-1:0]   mem_mask,
  input  logic                    mem_ack,
  input  logic [8*DATASIZE-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int STREAK_W = MAX_RD_STREAK;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  state_e              state;
  state_e              state_d;
  state_e              grant;
  logic [STREAK_W-1:0] rd_streak;
  logic                streak_sat;

  assign streak_sat = (rd_streak == STREAK_MAX);

  mem_arb_select u_select (
    .wb_valid   (wb_valid),
    .wb_full    (wb_full),
    .rd_req     (rd_req),
    .rd_hazard  (rd_hazard),
    .rd_block   (rd_ready),
    .streak_sat (streak_sat),
    .grant      (grant)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:        state_d = grant;
      WRITE, READ: if (mem_ack) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_streak   <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_mask    <= '0;
      rd_data     <= '0;
      rd_ready    <= 1'b0;
    end else begin
      state    <= state_d;
      rd_ready <= 1'b0;

      if (state == IDLE) begin
        unique case (grant)
          WRITE: begin
            mem_address <= wb_address;
            mem_wdata   <= wb_data;
            mem_mask    <= wb_mask;
            rd_streak   <= '0;
          end
          READ: begin
            mem_address <= rd_address;
            mem_wdata   <= '0;
            mem_mask    <= '0;
            if (!wb_valid) begin
              rd_streak <= '0;
            end else if (!streak_sat) begin
              rd_streak <= rd_streak + STREAK_ONE;
            end
          end
          default: begin
            if (!wb_valid) rd_streak <= '0;
          end
        endcase
      end

      if (state == READ && mem_ack) begin
        rd_data  <= mem_rdata;
        rd_ready <= 1'b1;
      end
    end
  end

  // Reset wins over a same-cycle ack: the abandoned write must not retire.
  assign wb_done = (state == WRITE) & mem_ack & ~reset;
  assign mem_req = is_active(state);
  assign mem_we  = (state == WRITE);
  assign busy    = is_active(state);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: write, read priority,
// hazard ordering, read-streak limit, full buffer and mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 8 * 64;

  logic          clk;
  logic          reset;
  logic          wb_valid, wb_full, wb_done;
  logic [AW-1:0] wb_address;
  logic [DW-1:0] wb_data, wb_mask;
  logic          rd_req, rd_hazard, rd_ready;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] rd_data;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_mask, mem_rdata;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_full     (wb_full),
    .wb_address  (wb_address),
    .wb_data     (wb_data),
    .wb_mask     (wb_mask),
    .wb_done     (wb_done),
    .rd_req      (rd_req),
    .rd_address  (rd_address),
    .rd_hazard   (rd_hazard),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_mask    (mem_mask),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [DW-1:0] pat_a5, pat_3c, pat_11, data_w1, mask_w1, data_w2;
  bit   [4:0]    seq;
  int            n_txn;
  int            n_rdy;

  initial begin
    pat_a5  = {64{8'hA5}};
    pat_3c  = {64{8'h3C}};
    pat_11  = {64{8'h11}};
    data_w1 = {8{64'h0123_4567_89AB_CDEF}};
    mask_w1 = {32{16'h00FF}};
    data_w2 = {16{32'hCAFE_F00D}};
    seq     = '0;

    reset = 1'b1; wb_valid = 0; wb_full = 0; wb_address = '0; wb_data = '0; wb_mask = '0;
    rd_req = 0; rd_address = '0; rd_hazard = 0; mem_ack = 0; mem_rdata = '0;

    // Reset state
    next_cycle();
    next_cycle();
    sample();
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wb_done", wb_done, 0);

    // Single write: grant in cycle 0, transaction cycles 1..3, ack in cycle 3
    next_cycle();
    reset = 0; wb_valid = 1; wb_address = 32'h100; wb_data = data_w1; wb_mask = mask_w1;
    sample();
    check("w_c0_mem_req", mem_req, 0);
    next_cycle();
    wb_valid = 0; wb_address = 32'hDEAD; wb_data = '0; wb_mask = '0;
    sample();
    check("w_c1_mem_req", mem_req, 1);
    check("w_c1_mem_we", mem_we, 1);
    check("w_c1_addr", mem_address, 32'h100);
    check("w_c1_wdata", mem_wdata, data_w1);
    check("w_c1_mask", mem_mask, mask_w1);
    next_cycle();
    sample();
    check("w_c2_addr_hold", mem_address, 32'h100);
    check("w_c2_wb_done", wb_done, 0);
    next_cycle();
    mem_ack = 1;
    sample();
    check("w_c3_wb_done", wb_done, 1);
    next_cycle();
    mem_ack = 0;
    sample();
    check("w_c4_busy", busy, 0);
    check("w_c4_wb_done", wb_done, 0);

    // Read priority over a pending non-urgent write; ack in first READ cycle
    next_cycle();
    rd_req = 1; rd_address = 32'h200; wb_valid = 1; wb_address = 32'h300; wb_data = data_w2;
    next_cycle();
    mem_ack = 1; mem_rdata = pat_a5;
    sample();
    check("rp_mem_req", mem_req, 1);
    check("rp_mem_we", mem_we, 0);
    check("rp_addr", mem_address, 32'h200);
    check("rp_wb_done", wb_done, 0);
    next_cycle();
    mem_ack = 0; mem_rdata = '0;
    sample();
    check("rp_rd_ready", rd_ready, 1);
    check("rp_rd_data", rd_data, pat_a5);
    check("rp_busy_rdy", busy, 0);
    next_cycle();
    rd_req = 0;
    sample();
    check("rp_rd_ready_once", rd_ready, 0);
    check("rp_no_reserve", busy, 0);
    next_cycle();
    mem_ack = 1;
    sample();
    check("rp_w_we", mem_we, 1);
    check("rp_w_addr", mem_address, 32'h300);
    check("rp_w_wdata", mem_wdata, data_w2);
    check("rp_rd_data_hold", rd_data, pat_a5);
    check("rp_w_done", wb_done, 1);
    next_cycle();
    mem_ack = 0; wb_valid = 0;
    sample();
    check("rp_end_busy", busy, 0);

    // Hazard: the matching write must go first
    next_cycle();
    rd_req = 1; rd_address = 32'h400; rd_hazard = 1; wb_valid = 1; wb_address = 32'h500;
    next_cycle();
    mem_ack = 1;
    sample();
    check("hz_first_we", mem_we, 1);
    check("hz_first_addr", mem_address, 32'h500);
    check("hz_wb_done", wb_done, 1);
    next_cycle();
    wb_valid = 0; rd_hazard = 0; mem_ack = 0;
    sample();
    check("hz_gap_busy", busy, 0);
    next_cycle();
    mem_ack = 1; mem_rdata = pat_3c;
    sample();
    check("hz_second_we", mem_we, 0);
    check("hz_second_addr", mem_address, 32'h400);
    next_cycle();
    mem_ack = 0; mem_rdata = '0;
    sample();
    check("hz_rd_ready", rd_ready, 1);
    check("hz_rd_data", rd_data, pat_3c);
    next_cycle();
    rd_req = 0;
    sample();
    check("hz_end_busy", busy, 0);

    // Streak limit: continuous reads with a write pending -> R R R R W
    next_cycle();
    wb_valid = 1; wb_address = 32'h900; rd_req = 1; rd_address = 32'hA00;
    n_txn = 0;
    n_rdy = 0;
    for (int i = 0; i < 60 && n_txn < 5; i++) begin
      next_cycle();
      if (rd_ready) n_rdy++;
      mem_ack   = mem_req;
      mem_rdata = pat_11;
      if (mem_req) begin
        seq[n_txn] = mem_we;
        n_txn++;
      end
    end
    check("st_txn_count", 32'(n_txn), 32'd5);
    check("st_rd_ready_count", 32'(n_rdy), 32'd4);
    check("st_seq", {59'd0, seq}, {59'd0, 5'b10000});
    next_cycle();
    mem_ack = 0; wb_valid = 0; rd_req = 0; mem_rdata = '0;
    sample();
    check("st_end_busy", busy, 0);
    check("st_rd_data", rd_data, pat_11);

    // Full buffer overrides read priority; then reset during the write with ack
    next_cycle();
    wb_full = 1; wb_valid = 1; wb_address = 32'h700; wb_data = data_w1; wb_mask = mask_w1;
    rd_req = 1; rd_address = 32'h800;
    next_cycle();
    sample();
    check("fb_we", mem_we, 1);
    check("fb_addr", mem_address, 32'h700);
    next_cycle();
    reset = 1; mem_ack = 1;
    sample();
    check("rs_no_wb_done", wb_done, 0);
    next_cycle();
    reset = 0; mem_ack = 0; wb_full = 0; wb_valid = 0; rd_req = 0;
    sample();
    check("rs_busy", busy, 0);
    check("rs_mem_req", mem_req, 0);
    check("rs_mem_we", mem_we, 0);
    check("rs_addr", mem_address, 0);
    check("rs_wdata", mem_wdata, 0);
    check("rs_mask", mem_mask, 0);
    check("rs_rd_data", rd_data, 0);
    check("rs_rd_ready", rd_ready, 0);
    check("rs_wb_done", wb_done, 0);

    // Stray ack in IDLE has no effect
    next_cycle();
    mem_ack = 1;
    sample();
    check("ia_busy", busy, 0);
    check("ia_wb_done", wb_done, 0);
    next_cycle();
    mem_ack = 0;
    sample();
    check("ia_rd_ready", rd_ready, 0);
    check("ia_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDRESSIZE, default 32, address width in bits.
- DATASIZE, default 64, line size in bytes.
- MAX_RD_STREAK, default 4, maximum consecutive read grants while a write is pending.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- wb_valid, in, 1, write buffer head entry present.
- wb_full, in, 1, write buffer full.
- wb_address, in, ADDRESSIZE, head entry address.
- wb_data, in, 8*DATASIZE, head entry data.
- wb_mask, in, 8*DATASIZE, head entry mask.
- wb_done, out, 1, one-cycle pulse: head entry written; drives write buffer done.
- rd_req, in, 1, cache line-fill request; held until rd_ready.
- rd_address, in, ADDRESSIZE, fill address.
- rd_hazard, in, 1, rd_address matches a buffered write.
- rd_ready, out, 1, one-cycle pulse: rd_data valid.
- rd_data, out, 8*DATASIZE, fill data.
- mem_req, out, 1, memory transaction active.
- mem_we, out, 1, 1 = write, 0 = read.
- mem_address, out, ADDRESSIZE, memory address.
- mem_wdata, out, 8*DATASIZE, memory write data.
- mem_mask, out, 8*DATASIZE, memory write mask.
- mem_ack, in, 1, memory completes the current transaction this cycle.
- mem_rdata, in, 8*DATASIZE, memory read data, valid with mem_ack.
- busy, out, 1, state is not IDLE.

Function
REQ-003 The block SHALL use an FSM with states IDLE, WRITE and READ.
REQ-004 In IDLE, the block SHALL grant WRITE when wb_valid & (wb_full | (rd_req & rd_hazard) | ~rd_req | rd_streak == MAX_RD_STREAK).
REQ-005 In IDLE, the block SHALL otherwise grant READ when rd_req.
REQ-006 In IDLE, the block SHALL stay in IDLE when neither rd_req nor wb_valid is asserted.
REQ-007 On a grant, the block SHALL capture the address, data and mask into registers; mem_* SHALL be driven only from these registers.
REQ-008 The memory transaction SHALL start one cycle after the grant edge.
REQ-009 In WRITE and READ, mem_req SHALL be 1; mem_we SHALL be 1 in WRITE and 0 in READ.
REQ-010 The block SHALL hold all mem_* outputs stable until mem_ack.
REQ-011 mem_ack in the first WRITE/READ cycle SHALL be accepted, giving a minimum 2-cycle service time.
REQ-012 On mem_ack in WRITE, wb_done SHALL pulse 1 in that same cycle and the next state SHALL be IDLE.
REQ-013 On mem_ack in READ, rd_data SHALL register mem_rdata, rd_ready SHALL pulse 1 in the following cycle, and the next state SHALL be IDLE.
REQ-014 rd_data SHALL hold its value until the next read completes.
REQ-015 rd_req SHALL be ignored for the cycle in which rd_ready=1, so one request is not served twice.
REQ-016 mem_ack SHALL be ignored in IDLE.
REQ-017 rd_streak, MAX_RD_STREAK bits wide, SHALL:
- increment on each READ grant while wb_valid=1;
- clear on each WRITE grant;
- clear on any IDLE cycle with wb_valid=0;
- saturate at MAX_RD_STREAK.
REQ-018 wb_done SHALL assert at most once per WRITE and never outside WRITE.
REQ-019 busy SHALL equal (state != IDLE).

Reset
REQ-020 When reset=1 at a rising edge, the block SHALL:
- enter IDLE;
- clear rd_streak;
- drive all outputs to 0, including mem_req, mem_we, mem_address, mem_wdata, mem_mask, wb_done, rd_ready, rd_data and busy.
REQ-021 A reset during WRITE or READ SHALL abandon the transaction with no wb_done or rd_ready pulse.
REQ-022 Reset SHALL take priority over mem_ack in the same cycle.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'b00, WRITE=2'b01, READ=2'b10) and the default parameter values.
REQ-024 The grant decision in REQ-004 to REQ-006 MAY be a combinational sub-module, mem_arb_select; the FSM, capture registers and rd_streak SHALL stay in mem_port_arbiter.

Verification
REQ-025 Single write: wb_valid=1, wb_address=0x100, rd_req=0 -> mem_req=1, mem_we=1, mem_address=0x100 from cycle 1; mem_ack at cycle 3 -> wb_done=1 at cycle 3, busy=0 at cycle 4.
REQ-026 Read priority: rd_req=1 (0x200), wb_valid=1, rd_hazard=0, wb_full=0 -> READ granted first; mem_rdata=0xA5.. with ack -> rd_ready=1 next cycle, rd_data=0xA5..; WRITE follows.
REQ-027 Hazard: rd_req=1, rd_hazard=1, wb_valid=1 -> WRITE granted before READ.
REQ-028 Starvation: rd_req held with back-to-back requests, wb_valid=1, MAX_RD_STREAK=4 -> exactly 4 READs, then 1 WRITE.
REQ-029 Reset mid-op: reset=1 in the 2nd WRITE cycle with mem_ack=1 -> no wb_done pulse, all outputs 0, state IDLE next cycle.
REQ-030 Full buffer: wb_full=1, wb_valid=1, rd_req=1, rd_hazard=0 -> WRITE granted.
